// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: CPU, EXT, fill-control and data-memory signals of the data-memory arbiter
interface dm_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wd;
    logic [31:0] cpu_pc;
    logic [31:0] cpu_rd;
    logic        cpu_stall;
    logic        ext_req;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wd;
    logic        ext_ack;
    logic [31:0] ext_rd;
    logic        ext_err;
    logic        clr_start;
    logic        clr_busy;
    logic        dm_we;
    logic        dm_re;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [31:0] dm_pc;
    logic [31:0] dm_rd;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wd, cpu_pc,
        output cpu_rd, cpu_stall,
        input  ext_req, ext_we, ext_addr, ext_wd,
        output ext_ack, ext_rd, ext_err,
        input  clr_start,
        output clr_busy,
        output dm_we, dm_re, dm_addr, dm_wd, dm_pc,
        input  dm_rd
    );

    // Requester / memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wd, cpu_pc,
        input  cpu_rd, cpu_stall,
        output ext_req, ext_we, ext_addr, ext_wd,
        input  ext_ack, ext_rd, ext_err,
        output clr_start,
        input  clr_busy,
        input  dm_we, dm_re, dm_addr, dm_wd, dm_pc,
        output dm_rd
    );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one data-memory access per cycle between CPU, EXT port and a zero-fill engine
module dm_arbiter #(
    parameter int DEPTH = 3072
) (
    input logic       clk,
    input logic       reset,
    dm_arbiter_if.slave bus
);
    localparam int CW = $clog2(DEPTH);

    typedef enum logic {ARB, CLEAR} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_ext_q, last_ext_d;
    logic          ext_ack_q, ext_ack_d;
    logic          ext_err_q, ext_err_d;
    logic [31:0]   ext_rd_q, ext_rd_d;
    logic          ext_in_range, ext_ok, grant_cpu, grant_ext;

    // Round-robin grant; EXT is masked in its ack cycle so a still-held request is not served twice
    always_comb begin
        ext_in_range = bus.ext_addr[31:2] < 30'(DEPTH);
        ext_ok       = bus.ext_req && !ext_ack_q;
        grant_cpu    = (state_q == ARB) && bus.cpu_req && (!ext_ok || last_ext_q);
        grant_ext    = (state_q == ARB) && ext_ok && (!bus.cpu_req || !last_ext_q);
    end

    // Memory port mux plus the combinational CPU response and registered EXT response
    always_comb begin
        bus.dm_we   = 1'b0;
        bus.dm_re   = 1'b0;
        bus.dm_addr = '0;
        bus.dm_wd   = '0;
        bus.dm_pc   = '0;
        if (state_q == CLEAR) begin
            bus.dm_we   = 1'b1;
            bus.dm_addr = {{(30-CW){1'b0}}, cnt_q, 2'b00};
        end else if (grant_cpu) begin
            bus.dm_we   = bus.cpu_we;
            bus.dm_re   = !bus.cpu_we;
            bus.dm_addr = bus.cpu_addr;
            bus.dm_wd   = bus.cpu_wd;
            bus.dm_pc   = bus.cpu_pc;
        end else if (grant_ext && ext_in_range) begin
            bus.dm_we   = bus.ext_we;
            bus.dm_re   = !bus.ext_we;
            bus.dm_addr = bus.ext_addr;
            bus.dm_wd   = bus.ext_wd;
        end
        bus.cpu_rd    = grant_cpu ? bus.dm_rd : '0;
        bus.cpu_stall = bus.cpu_req && !grant_cpu;
        bus.clr_busy  = state_q == CLEAR;
        bus.ext_ack   = ext_ack_q;
        bus.ext_err   = ext_err_q;
        bus.ext_rd    = ext_rd_q;
    end

    // Next state: fill sweep counter, round-robin history and the EXT response registers
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_ext_d = grant_ext ? 1'b1 : grant_cpu ? 1'b0 : last_ext_q;
        ext_ack_d  = grant_ext;
        ext_err_d  = grant_ext && !ext_in_range;
        ext_rd_d   = ext_rd_q;
        if (grant_ext && !ext_in_range)
            ext_rd_d = '0;
        else if (grant_ext && !bus.ext_we)
            ext_rd_d = bus.dm_rd;
        if (state_q == ARB && bus.clr_start) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end else if (state_q == CLEAR) begin
            state_d = (cnt_q == CW'(DEPTH - 1)) ? ARB : CLEAR;
            cnt_d   = (cnt_q == CW'(DEPTH - 1)) ? '0 : cnt_q + 1'b1;
        end
    end

    // State registers; last_grant resets to EXT so the CPU wins the first tie
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ARB;
            cnt_q      <= '0;
            last_ext_q <= 1'b1;
            ext_ack_q  <= 1'b0;
            ext_err_q  <= 1'b0;
            ext_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_ext_q <= last_ext_d;
            ext_ack_q  <= ext_ack_d;
            ext_err_q  <= ext_err_d;
            ext_rd_q   <= ext_rd_d;
        end
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench with a behavioural memory model for dm_arbiter
module tb_dm_arbiter;
    localparam int DEPTH = 3072;

    typedef struct packed {
        logic        err;
        logic [31:0] rd;
    } ext_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dm_arbiter_if bus();
    dm_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [31:0] mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] cpu_q [$];
    ext_t        ext_q [$];
    logic [31:0] ext_rd_model = '0;
    int          cmp_cnt = 0;
    int          err_cnt = 0;

    // Data memory: combinational read, write on the rising edge
    always_comb bus.dm_rd = (bus.dm_addr[31:2] < 30'(DEPTH)) ? mem[bus.dm_addr[13:2]] : 32'h0;
    always @(posedge clk) if (bus.dm_we && bus.dm_addr[31:2] < 30'(DEPTH)) mem[bus.dm_addr[13:2]] = bus.dm_wd;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a response
    always @(negedge clk) begin
        ext_t e;
        if (bus.ext_ack) begin
            if (ext_q.size() == 0) chk("ext_unexpected_ack", 32'(ext_q.size()), 32'd1);
            else begin
                e = ext_q.pop_front();
                chk("ext_err", 32'(bus.ext_err), 32'(e.err));
                chk("ext_rd", bus.ext_rd, e.rd);
            end
        end
        if (bus.cpu_req && !bus.cpu_stall) begin
            chk("cpu_dm_addr", bus.dm_addr, bus.cpu_addr);
            chk("cpu_dm_pc", bus.dm_pc, bus.cpu_pc);
            chk("cpu_dm_we", 32'(bus.dm_we), 32'(bus.cpu_we));
            chk("cpu_dm_re", 32'(bus.dm_re), 32'(!bus.cpu_we));
            if (bus.cpu_we) chk("cpu_dm_wd", bus.dm_wd, bus.cpu_wd);
            else if (cpu_q.size() == 0) chk("cpu_unexpected_grant", 32'(cpu_q.size()), 32'd1);
            else chk("cpu_rd", bus.cpu_rd, cpu_q.pop_front());
        end
        if (bus.dm_we || bus.dm_re) chk("dm_in_range", 32'(bus.dm_addr[31:2] < 30'(DEPTH)), 32'd1);
    end

    task automatic do_reset();
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wd = 0; bus.cpu_pc = 0;
        bus.ext_req = 0; bus.ext_we = 0; bus.ext_addr = 0; bus.ext_wd = 0; bus.clr_start = 0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ext_ack", 32'(bus.ext_ack), 32'd0);
        chk("rst_ext_err", 32'(bus.ext_err), 32'd0);
        chk("rst_ext_rd", bus.ext_rd, 32'd0);
        chk("rst_clr_busy", 32'(bus.clr_busy), 32'd0);
        chk("rst_dm_we", 32'(bus.dm_we), 32'd0);
        chk("rst_dm_re", 32'(bus.dm_re), 32'd0);
        chk("rst_dm_addr", bus.dm_addr, 32'd0);
        chk("rst_dm_pc", bus.dm_pc, 32'd0);
        reset = 1'b1;
        ext_rd_model = '0;
    endtask

    task automatic cpu_op(input logic we, input logic [31:0] a, input logic [31:0] d);
        int n;
        @(posedge clk); #1;
        bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wd = d; bus.cpu_pc = $urandom;
        if (we) ref_mem[a[13:2]] = d;
        else cpu_q.push_back(ref_mem[a[13:2]]);
        n = 0;
        do begin @(negedge clk); n++; end while (bus.cpu_stall && n < 4000);
        chk("cpu_grant_timeout", 32'(bus.cpu_stall), 32'd0);
    endtask

    task automatic cpu_idle();
        @(posedge clk); #1;
        bus.cpu_req = 0;
    endtask

    task automatic ext_op(input logic we, input logic [31:0] a, input logic [31:0] d);
        int   n;
        ext_t e;
        @(posedge clk); #1;
        bus.ext_req = 1; bus.ext_we = we; bus.ext_addr = a; bus.ext_wd = d;
        e.err = a[31:2] >= 30'(DEPTH);
        if (e.err) e.rd = '0;
        else if (we) begin ref_mem[a[13:2]] = d; e.rd = ext_rd_model; end
        else e.rd = ref_mem[a[13:2]];
        ext_rd_model = e.rd;
        ext_q.push_back(e);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.ext_ack && n < 100);
        chk("ext_ack_timeout", 32'(bus.ext_ack), 32'd1);
        @(posedge clk); #1;
        bus.ext_req = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        do_reset();

        // CPU write then read, zero-latency, no stall
        cpu_op(1'b1, 32'h10, 32'hDEADBEEF);
        chk("t1_dm_we", 32'(bus.dm_we), 32'd1);
        cpu_op(1'b0, 32'h10, 32'h0);
        chk("t1_no_stall", 32'(bus.cpu_stall), 32'd0);
        cpu_idle();

        // Continuous CPU/EXT contention alternates C,E,C,E from reset
        do_reset();
        @(posedge clk); #1;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h50; bus.cpu_pc = 32'h400;
        bus.ext_req = 1; bus.ext_we = 0; bus.ext_addr = 32'h1770;
        for (int i = 0; i < 4; i++) begin
            cpu_q.push_back(ref_mem[20]);
            ext_q.push_back('{err: 1'b0, rd: ref_mem[1500]});
        end
        ext_rd_model = ref_mem[1500];
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("alt_stall", 32'(bus.cpu_stall), 32'(k % 2));
            chk("alt_ack", 32'(bus.ext_ack), 32'(k > 0 && k % 2 == 0));
        end
        @(posedge clk); #1;
        bus.cpu_req = 0; bus.ext_req = 0;
        repeat (2) @(negedge clk);
        chk("alt_cpu_drained", 32'(cpu_q.size()), 32'd0);
        chk("alt_ext_drained", 32'(ext_q.size()), 32'd0);

        // EXT boundary: last word in range, first word out of range, write holds rd
        ext_op(1'b0, 32'h2FFC, 32'h0);
        ext_op(1'b0, 32'h3000, 32'h0);
        ext_op(1'b0, 32'h0000_1003, 32'h0);
        ext_op(1'b1, 32'h0000_2000, 32'hCAFE_F00D);
        ext_op(1'b0, 32'h0000_2000, 32'h0);

        // Zero-fill with a CPU request held throughout and a retrigger mid-fill
        cpu_op(1'b1, 32'h40, 32'h1234_5678);
        cpu_idle();
        bus.clr_start = 1;
        @(posedge clk); #1;
        bus.clr_start = 0;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h40;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        cpu_q.push_back(32'h0);
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            chk("clr_busy", 32'(bus.clr_busy), 32'd1);
            chk("clr_dm_we", 32'(bus.dm_we), 32'd1);
            chk("clr_dm_addr", bus.dm_addr, 32'(k * 4));
            chk("clr_dm_wd", bus.dm_wd, 32'd0);
            chk("clr_stall", 32'(bus.cpu_stall), 32'd1);
            bus.clr_start = (k == 500);
        end
        @(negedge clk);
        chk("clr_done_busy", 32'(bus.clr_busy), 32'd0);
        chk("clr_done_grant", 32'(bus.cpu_stall), 32'd0);
        cpu_idle();

        // Reset asserted mid-fill at cnt=100
        cpu_op(1'b1, 32'h190, 32'hA5A5_0100);
        cpu_op(1'b1, 32'hC8, 32'h0000_BEEF);
        cpu_idle();
        bus.clr_start = 1;
        @(posedge clk); #1;
        bus.clr_start = 0;
        for (int k = 0; k <= 100; k++) @(negedge clk);
        chk("abort_addr", bus.dm_addr, 32'd400);
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.clr_busy), 32'd0);
        chk("abort_dm_we", 32'(bus.dm_we), 32'd0);
        for (int i = 0; i < 100; i++) ref_mem[i] = '0;
        @(negedge clk);
        reset = 1'b1;
        ext_rd_model = '0;
        ext_op(1'b0, 32'h18C, 32'h0);
        ext_op(1'b0, 32'h190, 32'h0);
        ext_op(1'b0, 32'hC8, 32'h0);

        // Randomized concurrent CPU (words 0..1023) and EXT (words 1024.. and out of range) traffic
        fork
            begin
                repeat (300) begin
                    a = {20'h0, 10'($urandom), 2'($urandom)};
                    cpu_op(1'($urandom), a, $urandom);
                    if ($urandom_range(2) == 0) cpu_idle();
                end
                cpu_idle();
            end
            begin
                logic [31:0] ea;
                repeat (150) begin
                    if ($urandom_range(7) == 0)
                        ea = ($urandom_range(1) == 1) ? (32'h3000 + ($urandom & 32'hFFF)) : ($urandom | 32'h8000_0000);
                    else
                        ea = {18'h0, 12'(1024 + $urandom_range(2047)), 2'($urandom)};
                    ext_op(1'($urandom), ea, $urandom);
                end
            end
        join
        repeat (4) @(negedge clk);
        chk("final_cpu_drained", 32'(cpu_q.size()), 32'd0);
        chk("final_ext_drained", 32'(ext_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
